// File: rtl/conv_enc_pkg.sv
// Shared constants and puncturing rules for the punctured convolutional encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_enc_pkg;

  localparam int         K_80211A  = 7;
  localparam logic [6:0] G0_80211A = 7'o133;
  localparam logic [6:0] G1_80211A = 7'o171;

  localparam logic [1:0] RATE_1_2  = 2'b00;
  localparam logic [1:0] RATE_2_3  = 2'b01;
  localparam logic [1:0] RATE_3_4  = 2'b10;
  localparam logic [1:0] RATE_RSVD = 2'b11;

  // {emit_a, emit_b} for one input bit at the given rate and puncture phase.
  function automatic logic [1:0] puncture_mask(input logic [1:0] rate, input logic [1:0] phase);
    logic [1:0] mask;
    mask = 2'b11;
    case (rate)
      RATE_2_3: mask = (phase == 2'd1) ? 2'b10 : 2'b11;
      RATE_3_4: begin
        case (phase)
          2'd1:    mask = 2'b10;
          2'd2:    mask = 2'b01;
          default: mask = 2'b11;
        endcase
      end
      default:  mask = 2'b11;
    endcase
    return mask;
  endfunction

  // Number of input bits in one puncture period.
  function automatic logic [1:0] puncture_period(input logic [1:0] rate);
    logic [1:0] period;
    case (rate)
      RATE_2_3: period = 2'd2;
      RATE_3_4: period = 2'd3;
      default:  period = 2'd1;
    endcase
    return period;
  endfunction

endpackage

// File: rtl/conv_pending_buffer.sv
// Two-bit holding register for the coded bits of one input bit, drained one bit per cycle.
// Latency: a loaded head bit is visible on out_data the cycle after load.
// Backpressure: out_data holds while out_valid && !out_ready; can_load only when the load cannot overflow.
module conv_pending_buffer (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [1:0] load_bits,
  input  logic       load_two,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       out_data,
  output logic       can_load
);

  // bits_q[0] is the head; bits_q[1] follows it when count_q == 2.
  logic [1:0] bits_q;
  logic [1:0] count_q;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = bits_q[0];
  // Space exists when empty, or when the single remaining bit leaves this cycle.
  assign can_load  = (count_q == 2'd0) || ((count_q == 2'd1) && out_ready);

  // Load replaces the contents (the old head, if any, departs this cycle); otherwise shift out on transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bits_q  <= 2'b00;
      count_q <= 2'd0;
    end else if (clear) begin
      bits_q  <= 2'b00;
      count_q <= 2'd0;
    end else if (load) begin
      bits_q  <= load_bits;
      count_q <= load_two ? 2'd2 : 2'd1;
    end else if (out_valid && out_ready) begin
      bits_q  <= {1'b0, bits_q[1]};
      count_q <= count_q - 2'd1;
    end
  end

endmodule

// File: rtl/punctured_conv_encoder.sv
// 802.11a convolutional encoder with rate 1/2, 2/3, 3/4 puncturing and an internal tail flush.
// Latency: the first coded bit of an input accepted in cycle N is on OutData in cycle N+1.
// Backpressure: InReady is combinational from OutReady and the pending count; OutData holds while stalled.
module punctured_conv_encoder
  import conv_enc_pkg::*;
#(
  parameter int             K             = K_80211A,
  parameter logic [K-1:0]   G0            = G0_80211A,
  parameter logic [K-1:0]   G1            = G1_80211A,
  parameter logic [K-2:0]   INITIAL_STATE = '0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Rate,
  input  logic       Flush,
  input  logic       InValid,
  input  logic       InData,
  output logic       InReady,
  output logic       OutValid,
  output logic       OutData,
  input  logic       OutReady,
  output logic       Busy
);

  localparam int            CW       = $clog2(K);
  localparam logic [CW-1:0] TAIL_LEN = CW'(K - 1);

  // sr_q[K-2] is the previous input bit, sr_q[0] the oldest one still in the register.
  logic [K-2:0]  sr_q;
  logic [1:0]    rate_q;
  logic [1:0]    phase_q;
  logic [CW-1:0] flush_cnt_q;

  logic          flushing;
  logic          can_load;
  logic          accept;
  logic          flush_step;
  logic          flush_last;
  logic          feed;
  logic          feed_bit;
  logic [K-1:0]  taps;
  logic          bit_a;
  logic          bit_b;
  logic [1:0]    mask;
  logic [1:0]    period;
  logic [1:0]    phase_next;
  logic [1:0]    load_bits;
  logic          load_two;

  assign flushing   = (flush_cnt_q != '0);
  assign InReady    = !Reset && !flushing && !Start && can_load;
  assign accept     = InValid && InReady;
  // Tail zeros go in whenever the buffer has room; Start cancels the flush.
  assign flush_step = flushing && can_load && !Start;
  assign flush_last = flush_step && (flush_cnt_q == CW'(1));
  assign feed       = accept || flush_step;
  assign feed_bit   = accept & InData;

  assign taps       = {feed_bit, sr_q};
  assign bit_a      = ^(taps & G0);
  assign bit_b      = ^(taps & G1);

  assign mask       = puncture_mask(rate_q, phase_q);
  assign period     = puncture_period(rate_q);
  assign phase_next = (phase_q == period - 2'd1) ? 2'd0 : phase_q + 2'd1;

  // A B-only phase puts B at the head; otherwise A leads and B follows when present.
  assign load_bits  = (mask == 2'b01) ? {1'b0, bit_b} : {bit_b, bit_a};
  assign load_two   = &mask;

  assign Busy       = flushing || OutValid;

  // Shift register, puncture phase and latched rate; Start restarts the code sequence.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sr_q    <= INITIAL_STATE;
      phase_q <= 2'd0;
      rate_q  <= RATE_1_2;
    end else if (Start) begin
      sr_q    <= INITIAL_STATE;
      phase_q <= 2'd0;
      rate_q  <= (Rate == RATE_RSVD) ? RATE_1_2 : Rate;
    end else if (feed) begin
      sr_q    <= flush_last ? INITIAL_STATE : {feed_bit, sr_q[K-2:1]};
      phase_q <= phase_next;
    end
  end

  // Tail counter: loads K-1 on an idle Flush and counts down once per injected zero.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      flush_cnt_q <= '0;
    end else if (Start) begin
      flush_cnt_q <= '0;
    end else if (Flush && !flushing) begin
      flush_cnt_q <= TAIL_LEN;
    end else if (flush_step) begin
      flush_cnt_q <= flush_cnt_q - CW'(1);
    end
  end

  conv_pending_buffer u_pending (
    .clock     (Clock),
    .reset     (Reset),
    .clear     (Start),
    .load      (feed),
    .load_bits (load_bits),
    .load_two  (load_two),
    .out_ready (OutReady),
    .out_valid (OutValid),
    .out_data  (OutData),
    .can_load  (can_load)
  );

endmodule

// File: tb/tb_punctured_conv_encoder.sv
// Self-checking bench for the punctured convolutional encoder.
// Drives directed and random sequences; a queue-based reference model predicts every coded bit.
// Output stalls are produced by randomizing OutReady during the backpressure section.
module tb_punctured_conv_encoder;

  logic       Clock = 1'b0;
  logic       Reset, Start, Flush, InValid, InData, OutReady;
  logic [1:0] Rate;
  logic       InReady, OutValid, OutData, Busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: history of previous input bits (newest first) and a textual puncture table.
  logic [6:0] g0 = 7'o133;
  logic [6:0] g1 = 7'o171;
  string      pat [3][3];
  int         per [3] = '{1, 2, 3};
  int         hist [$];
  int         mrate  = 0;
  int         mphase = 0;
  bit         expq [$];
  bit         cap  [$];
  bit         ref_seq [$];
  bit         din [200];

  bit bp_mode    = 1'b0;
  bit prev_acc   = 1'b0;
  bit prev_stall = 1'b0;
  bit held       = 1'b0;
  bit last_acc   = 1'b0;

  punctured_conv_encoder dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Rate     (Rate),
    .Flush    (Flush),
    .InValid  (InValid),
    .InData   (InData),
    .InReady  (InReady),
    .OutValid (OutValid),
    .OutData  (OutData),
    .OutReady (OutReady),
    .Busy     (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    hist   = '{0, 0, 0, 0, 0, 0};
    mphase = 0;
    expq.delete();
  endfunction

  function automatic void model_feed(input bit b);
    bit    a, bb;
    string p;
    a  = b & g0[6];
    bb = b & g1[6];
    for (int i = 1; i < 7; i++) begin
      a  ^= hist[i-1][0] & g0[6-i];
      bb ^= hist[i-1][0] & g1[6-i];
    end
    p = pat[mrate][mphase];
    for (int j = 0; j < p.len(); j++) expq.push_back((p[j] == "A") ? a : bb);
    hist.push_front(int'(b));
    void'(hist.pop_back());
    mphase = (mphase + 1) % per[mrate];
  endfunction

  function automatic logic [31:0] cap_value();
    logic [31:0] v;
    v = '0;
    foreach (cap[i]) v = {v[30:0], cap[i]};
    return v;
  endfunction

  // One clock cycle: inputs already applied just after the falling edge; sample, check, advance model.
  task automatic cyc();
    if (bp_mode) OutReady = ($urandom_range(0, 9) < 3);
    #1;
    last_acc = 1'b0;
    if (Reset) begin
      check("rst_out_valid", OutValid, 0);
      check("rst_out_data", OutData, 0);
      check("rst_in_ready", InReady, 0);
      check("rst_busy", Busy, 0);
      model_clear();
      mrate      = 0;
      prev_acc   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", OutValid, 1);
        check("stall_data", OutData, held);
      end
      if (prev_acc) check("latency", OutValid, 1);
      check("busy", Busy, expq.size() != 0);
      if (expq.size() >= 2) check("ready_full", InReady, 0);
      if (expq.size() == 0 && !Start) check("ready_idle", InReady, 1);
      if (expq.size() == 0) check("no_spurious", OutValid, 0);
      else if (OutValid && OutReady) begin
        cap.push_back(OutData);
        check("out_bit", OutData, expq.pop_front());
      end
      last_acc   = InValid && InReady;
      prev_acc   = last_acc;
      prev_stall = OutValid && !OutReady && !Start;
      held       = OutData;
      if (Start) begin
        model_clear();
        mrate = (Rate == 2'b11) ? 0 : int'(Rate);
      end else begin
        if (last_acc) model_feed(InData);
        if (Flush) for (int i = 0; i < 6; i++) model_feed(1'b0);
      end
    end
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic send_bit(input bit b);
    InValid = 1'b1;
    InData  = b;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (last_acc) break;
    end
    check("send_accepted", last_acc, 1);
    InValid = 1'b0;
    InData  = 1'b0;
  endtask

  task automatic start_pulse(input logic [1:0] r);
    Start = 1'b1;
    Rate  = r;
    cyc();
    Start = 1'b0;
    cap.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && expq.size() != 0; i++) cyc();
    check("drain_empty", expq.size(), 0);
    cyc();
  endtask

  // Impulse (a single 1 followed by zeros) at one rate, compared with a hand-derived code word.
  task automatic run_impulse(input string tag, input logic [1:0] r, input int n_in,
                             input logic [31:0] exp_v, input int exp_n);
    start_pulse(r);
    Rate = ~r;
    for (int i = 0; i < n_in; i++) send_bit(i == 0);
    drain();
    check({tag, "_len"}, cap.size(), exp_n);
    check(tag, cap_value(), exp_v);
  endtask

  initial begin
    pat[0][0] = "AB";
    pat[1][0] = "AB"; pat[1][1] = "A";
    pat[2][0] = "AB"; pat[2][1] = "A"; pat[2][2] = "B";
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; InValid = 1'b0; InData = 1'b0;
    OutReady = 1'b1; Rate = 2'b00;
    model_clear();
    cyc();
    cyc();
    Reset = 1'b0;
    cyc();

    run_impulse("imp_r12", 2'b00, 7, 32'b11011111001011, 14);
    run_impulse("imp_r34", 2'b10, 6, 32'b11011100, 8);
    run_impulse("imp_r23", 2'b01, 4, 32'b110111, 6);
    run_impulse("imp_rsvd", 2'b11, 7, 32'b11011111001011, 14);

    // Random data with the output always ready, then the same data under 30% OutReady.
    foreach (din[i]) din[i] = 1'($urandom_range(0, 1));
    start_pulse(2'b00);
    foreach (din[i]) send_bit(din[i]);
    drain();
    ref_seq = cap;
    check("bp_ref_len", ref_seq.size(), 400);
    start_pulse(2'b00);
    bp_mode = 1'b1;
    foreach (din[i]) send_bit(din[i]);
    drain();
    bp_mode  = 1'b0;
    OutReady = 1'b1;
    check("bp_len", cap.size(), ref_seq.size());
    for (int i = 0; i < cap.size() && i < ref_seq.size(); i++) check("bp_seq", cap[i], ref_seq[i]);

    // Random data at rate 3/4 with backpressure, checked against the model only.
    start_pulse(2'b10);
    bp_mode = 1'b1;
    for (int i = 0; i < 60; i++) send_bit(1'($urandom_range(0, 1)));
    drain();
    bp_mode  = 1'b0;
    OutReady = 1'b1;

    // Tail flush after a single 1 reproduces the full rate-1/2 impulse response.
    start_pulse(2'b00);
    send_bit(1'b1);
    Flush = 1'b1;
    cyc();
    Flush = 1'b0;
    drain();
    check("flush_len", cap.size(), 14);
    check("flush_bits", cap_value(), 32'b11011111001011);

    // Flush then fresh data: the register is back at zero, so an impulse looks the same again.
    cap.delete();
    send_bit(1'b1);
    send_bit(1'b0);
    drain();
    check("post_flush", cap_value(), 32'b1101);

    // Reset while two coded bits are pending.
    start_pulse(2'b00);
    OutReady = 1'b0;
    send_bit(1'b1);
    cyc();
    Reset = 1'b1;
    cyc();
    Reset    = 1'b0;
    OutReady = 1'b1;
    repeat (4) cyc();

    // Start at rate 3/4 while in phase 1 of rate 2/3 with bits pending: restart at phase 0.
    start_pulse(2'b01);
    send_bit(1'b1);
    start_pulse(2'b10);
    send_bit(1'b1);
    send_bit(1'b0);
    drain();
    check("restart_len", cap.size(), 3);
    check("restart_bits", cap_value(), 32'b110);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
